// File: rtl/mips_pkg.sv
// Shared types and default vectors for the MIPS program-counter datapath.
package mips_pkg;

    typedef enum logic [2:0] {
        EXC,
        ADDR_ERR,
        ERET,
        RET,
        JR,
        J,
        BR,
        SEQ
    } pc_src_t;

    typedef enum logic {
        BOOT,
        RUN
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pushing when full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW:0]      count_q, count_d;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(RAS_DEPTH));
    // ptr_q names the next free slot, so the top lives one below it.
    assign top   = mem_q[ptr_q - PW'(1)];

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            if (!full) begin
                count_d = count_q + (PW+1)'(1);
            end
        end else if (pop && !empty) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fixed-priority next-PC selection, stall, EPC capture,
// misaligned-target trap and return-address stack.
module pc_unit
    import mips_pkg::*;
#(
    parameter int unsigned     WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             link,
    input  logic             jump_reg,
    input  logic             ret,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             exception,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_valid,
    output logic [WIDTH-1:0] epc,
    output logic             addr_error,
    output logic             ras_miss
);

    pc_state_t        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             addr_error_q, addr_error_d;
    logic             ras_miss_q, ras_miss_d;

    pc_src_t          src;
    logic [WIDTH-1:0] ret_target;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             misaligned;
    logic             update;
    logic             ras_push;
    logic             ras_pop;
    logic [WIDTH-1:0] jump_pc;
    logic [WIDTH-1:0] branch_pc;

    assign pc_plus4   = pc_q + WIDTH'(4);
    assign pc         = pc_q;
    assign epc        = epc_q;
    assign pc_valid   = pc_valid_q;
    assign addr_error = addr_error_q;
    assign ras_miss   = ras_miss_q;

    assign jump_pc   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
    assign branch_pc = pc_plus4 + {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};

    always_comb begin
        ret_target = ras_empty ? reg_target : ras_top;
        misaligned = (ret && (ret_target[1:0] != 2'b00)) ||
                     (jump_reg && (reg_target[1:0] != 2'b00));
        if (exception)         src = EXC;
        else if (misaligned)   src = ADDR_ERR;
        else if (eret)         src = ERET;
        else if (ret)          src = RET;
        else if (jump_reg)     src = JR;
        else if (jump)         src = J;
        else if (branch_taken) src = BR;
        else                   src = SEQ;
    end

    // Exception is the only request that breaks through a stall.
    assign update   = (state_q == RUN) && (!stall || exception);
    assign ras_push = update && link && ((src == J) || (src == JR));
    assign ras_pop  = update && (src == RET);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epc_d        = epc_q;
        pc_valid_d   = pc_valid_q;
        addr_error_d = 1'b0;
        ras_miss_d   = 1'b0;
        if (state_q == BOOT) begin
            state_d    = RUN;
            pc_valid_d = 1'b1;
        end else if (update) begin
            case (src)
                EXC: begin
                    pc_d  = EXC_VECTOR;
                    epc_d = pc_q;
                end
                ADDR_ERR: begin
                    pc_d         = EXC_VECTOR;
                    epc_d        = pc_q;
                    addr_error_d = 1'b1;
                end
                ERET: pc_d = epc_q;
                RET: begin
                    pc_d       = ret_target;
                    ras_miss_d = ras_empty;
                end
                JR:      pc_d = reg_target;
                J:       pc_d = jump_pc;
                BR:      pc_d = branch_pc;
                default: pc_d = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            pc_valid_q   <= 1'b0;
            addr_error_q <= 1'b0;
            ras_miss_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            pc_valid_q   <= pc_valid_d;
            addr_error_q <= addr_error_d;
            ras_miss_q   <= ras_miss_d;
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      ()
    );

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: queue-based reference model compared every cycle, plus
// directed literal checks and a randomized phase.
module tb_pc_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0040_0000;
    localparam logic [31:0] EV    = 32'h8000_0180;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, link = 1'b0;
    logic        jump_reg = 1'b0, ret = 1'b0, exception = 1'b0, eret = 1'b0;
    logic [15:0] branch_offset = '0;
    logic [25:0] jump_index    = '0;
    logic [31:0] reg_target    = '0;

    logic [31:0] pc, pc_plus4, epc;
    logic        pc_valid, addr_error, ras_miss;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc    = RV;
    logic [31:0] m_epc   = '0;
    logic        m_valid = 1'b0;
    logic        m_boot  = 1'b1;
    logic        m_ae    = 1'b0;
    logic        m_rm    = 1'b0;
    logic [31:0] m_ras[$];

    always #5 clock = ~clock;

    pc_unit #(
        .WIDTH        (32),
        .RESET_VECTOR (RV),
        .EXC_VECTOR   (EV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .link          (link),
        .jump_reg      (jump_reg),
        .ret           (ret),
        .reg_target    (reg_target),
        .exception     (exception),
        .eret          (eret),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .pc_valid      (pc_valid),
        .epc           (epc),
        .addr_error    (addr_error),
        .ras_miss      (ras_miss)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [31:0] p4, rt;
        logic        bad;
        m_ae = 1'b0;
        m_rm = 1'b0;
        if (m_boot) begin
            m_boot  = 1'b0;
            m_valid = 1'b1;
        end else if (!stall || exception) begin
            p4  = m_pc + 32'd4;
            rt  = (m_ras.size() == 0) ? reg_target : m_ras[m_ras.size()-1];
            bad = (ret && rt[1:0] != 2'b00) || (jump_reg && reg_target[1:0] != 2'b00);
            if (exception || bad) begin
                m_epc = m_pc;
                m_pc  = EV;
                m_ae  = !exception;
            end else if (eret) begin
                m_pc = m_epc;
            end else if (ret) begin
                if (m_ras.size() == 0) begin
                    m_pc = reg_target;
                    m_rm = 1'b1;
                end else begin
                    m_pc = m_ras.pop_back();
                end
            end else if (jump_reg || jump) begin
                if (link) begin
                    m_ras.push_back(p4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
                m_pc = jump_reg ? reg_target : {p4[31:28], jump_index, 2'b00};
            end else if (branch_taken) begin
                m_pc = p4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
            end else begin
                m_pc = p4;
            end
        end
    endtask

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            m_pc = RV; m_epc = '0; m_valid = 1'b0; m_boot = 1'b1;
            m_ae = 1'b0; m_rm = 1'b0;
            m_ras.delete();
        end else begin
            model_edge();
        end
    end

    initial forever begin
        @(negedge clock);
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("pc_valid", 32'(pc_valid), 32'(m_valid));
        check("epc", epc, m_epc);
        check("addr_error", 32'(addr_error), 32'(m_ae));
        check("ras_miss", 32'(ras_miss), 32'(m_rm));
    end

    task automatic idle();
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; link = 1'b0;
        jump_reg = 1'b0; ret = 1'b0; exception = 1'b0; eret = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic jr_to(input logic [31:0] t);
        idle();
        jump_reg   = 1'b1;
        reg_target = t;
        cyc();
        idle();
    endtask

    initial begin
        idle();
        repeat (3) cyc();
        check("rst_pc", pc, RV);
        check("rst_valid", 32'(pc_valid), 32'd0);
        check("rst_epc", epc, 32'd0);
        check("rst_pulses", {30'd0, addr_error, ras_miss}, 32'd0);

        reset_n = 1'b1;
        cyc();
        check("boot_valid", 32'(pc_valid), 32'd1);
        check("boot_pc", pc, RV);
        cyc();
        check("first_seq", pc, 32'h0040_0004);

        jr_to(32'h0040_0010);
        check("jr_pc", pc, 32'h0040_0010);
        stall = 1'b1; branch_taken = 1'b1; branch_offset = 16'hFFFC;
        cyc();
        check("br_stalled", pc, 32'h0040_0010);
        stall = 1'b0;
        cyc();
        check("br_back", pc, 32'h0040_0004);

        jr_to(32'h0040_0020);
        jump = 1'b1; jump_index = 26'h010_0008;
        cyc();
        check("j_pc", pc, 32'h0040_0020);
        idle();
        jump_reg = 1'b1; reg_target = 32'h0040_0102;
        cyc();
        idle();
        check("ae_pc", pc, EV);
        check("ae_epc", epc, 32'h0040_0020);
        check("ae_pulse", 32'(addr_error), 32'd1);
        cyc();
        check("ae_clear", 32'(addr_error), 32'd0);

        for (int i = 0; i < 5; i++) begin
            jump_reg = 1'b1; link = 1'b1;
            reg_target = 32'h0040_1000 + 32'(i * 256);
            cyc();
        end
        idle();
        for (int i = 3; i >= 0; i--) begin
            ret = 1'b1;
            cyc();
            check("ret_lifo", pc, 32'h0040_1004 + 32'(i * 256));
            check("ret_hit", 32'(ras_miss), 32'd0);
        end
        ret = 1'b1; reg_target = 32'h0040_2000;
        cyc();
        idle();
        check("ret_miss_pc", pc, 32'h0040_2000);
        check("ret_miss_pulse", 32'(ras_miss), 32'd1);

        jr_to(32'h0040_0044);
        exception = 1'b1; stall = 1'b1;
        cyc();
        idle();
        check("exc_pc", pc, EV);
        check("exc_epc", epc, 32'h0040_0044);
        repeat (3) cyc();
        eret = 1'b1;
        cyc();
        idle();
        check("eret_pc", pc, 32'h0040_0044);

        jr_to(32'hFFFF_FFFC);
        cyc();
        check("wrap", pc, 32'h0000_0000);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) begin
                idle();
                reset_n = 1'b0;
                cyc();
                reset_n = 1'b1;
            end else begin
                stall         = ($urandom_range(7) == 0);
                exception     = ($urandom_range(31) == 0);
                eret          = ($urandom_range(15) == 0);
                ret           = ($urandom_range(5) == 0);
                jump_reg      = ($urandom_range(5) == 0);
                jump          = ($urandom_range(5) == 0);
                branch_taken  = ($urandom_range(3) == 0);
                link          = ($urandom_range(1) == 0);
                branch_offset = 16'($urandom);
                jump_index    = 26'($urandom);
                reg_target    = $urandom;
                if ($urandom_range(7) != 0) reg_target[1:0] = 2'b00;
            end
            cyc();
        end

        idle();
        reset_n = 1'b1;
        repeat (3) cyc();
        jr_to(32'h0040_0300);
        reset_n = 1'b0;
        #1;
        check("async_rst_pc", pc, RV);
        check("async_rst_valid", 32'(pc_valid), 32'd0);
        cyc();
        reset_n = 1'b1;
        repeat (2) cyc();
        check("rerun_pc", pc, 32'h0040_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
